// File: rtl/uart_pattern_gen_if.sv
// uart_pattern_gen_if: transmit-side link between the pattern generator and
// the uart block. The generator is the master: it presents a byte and a
// one-cycle trigger, and the uart reports transmitter idle on tx_ready_i.
interface uart_pattern_gen_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] tx_data_o;
   logic              tx_trigger_o;
   logic              tx_ready_i;

   modport master (
      output tx_data_o,
      output tx_trigger_o,
      input  tx_ready_i
   );

   modport slave (
      input  tx_data_o,
      input  tx_trigger_o,
      output tx_ready_i
   );
endinterface

// File: rtl/uart_pattern_gen.sv
// uart_pattern_gen: UART transmit stimulus generator. Streams bytes from a
// writable pattern buffer, an incrementing counter or (optionally) a Galois
// LFSR into the uart transmitter, one trigger per ready period.
// Optional feature macro: UART_PATGEN_LFSR_EN builds the LFSR generator for
// mode 2; without it mode 2 behaves as the incrementing counter.
module uart_pattern_gen #(
   parameter int  DATA_W     = 8,
   parameter int  DEPTH      = 16,
   parameter int  CNT_W      = 16,
   parameter int  GAP_CYCLES = 0,
   localparam int AW         = $clog2(DEPTH)
) (
   input  logic               clk_i,
   input  logic               rst_n_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic [1:0]         mode_i,
   input  logic [CNT_W-1:0]   burst_len_i,
   input  logic [AW:0]        pat_len_i,
   input  logic [DATA_W-1:0]  seed_i,
   input  logic               wr_en_i,
   input  logic [AW-1:0]      wr_addr_i,
   input  logic [DATA_W-1:0]  wr_data_i,
   uart_pattern_gen_if.master tx_if,
   output logic               busy_o,
   output logic               done_o,
   output logic [CNT_W-1:0]   sent_count_o
);

`ifdef UART_PATGEN_LFSR_EN
   // The LFSR taps are defined for an 8-bit register only.
   if (DATA_W != 8) begin : g_lfsr_width_chk
      $error("uart_pattern_gen: LFSR generator requires DATA_W == 8");
   end
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_READY,
      S_TRIGGER,
      S_WAIT_ACCEPT,
      S_GAP,
      S_DONE
   } state_t;

   typedef enum logic [1:0] {
      GEN_BUF,
      GEN_INCR,
      GEN_LFSR
   } gen_sel_t;

   // Gap counter runs 0 .. GAP_CYCLES-1 while in S_GAP.
   localparam int             GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [GW-1:0]  GAP_LAST = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;
   localparam logic [AW:0]    PLEN_ONE = (AW+1)'(1);
   localparam logic [AW:0]    PLEN_MAX = (AW+1)'(DEPTH);

   state_t              state_q, state_d;
   gen_sel_t            gen_sel_q, gen_sel_d;
   logic [CNT_W-1:0]    burst_q, burst_d;
   logic [AW:0]         plen_q, plen_d;
   logic [AW-1:0]       idx_q, idx_d;
   logic [DATA_W-1:0]   gen_q, gen_d;
   logic [CNT_W-1:0]    sent_q, sent_d;
   logic                stop_pend_q, stop_pend_d;
   logic [GW-1:0]       gap_q, gap_d;
   logic [DATA_W-1:0]   tx_data_q, tx_data_d;
   logic [DATA_W-1:0]   mem_q [DEPTH];
   logic [DATA_W-1:0]   cur_byte;

   // Sent counter sticks at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // Buffer index wraps after the last valid entry of the pattern.
   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] i,
                                              input logic [AW:0]   len);
      return ({1'b0, i} == (len - PLEN_ONE)) ? '0 : i + AW'(1);
   endfunction

`ifdef UART_PATGEN_LFSR_EN
   // Galois LFSR step, taps 0xB8 (maximal length over the non-zero states).
   function automatic logic [DATA_W-1:0] lfsr_next(input logic [DATA_W-1:0] x);
      return (x >> 1) ^ (x[0] ? DATA_W'(8'hB8) : '0);
   endfunction
`endif

   // Byte the next trigger will present.
   assign cur_byte = (gen_sel_q == GEN_BUF) ? mem_q[idx_q] : gen_q;

   assign tx_if.tx_data_o    = tx_data_q;
   assign tx_if.tx_trigger_o = (state_q == S_TRIGGER);
   assign busy_o             = (state_q != S_IDLE);
   assign done_o             = (state_q == S_DONE);
   assign sent_count_o       = sent_q;

   // Pattern buffer write port; contents are not reset.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_data_i;
      end
   end

   // Control and generator state registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= S_IDLE;
         gen_sel_q   <= GEN_BUF;
         burst_q     <= '0;
         plen_q      <= PLEN_ONE;
         idx_q       <= '0;
         gen_q       <= '0;
         sent_q      <= '0;
         stop_pend_q <= 1'b0;
         gap_q       <= '0;
         tx_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         gen_sel_q   <= gen_sel_d;
         burst_q     <= burst_d;
         plen_q      <= plen_d;
         idx_q       <= idx_d;
         gen_q       <= gen_d;
         sent_q      <= sent_d;
         stop_pend_q <= stop_pend_d;
         gap_q       <= gap_d;
         tx_data_q   <= tx_data_d;
      end
   end

   // Next-state, run setup and generator advance.
   always_comb begin
      state_d     = state_q;
      gen_sel_d   = gen_sel_q;
      burst_d     = burst_q;
      plen_d      = plen_q;
      idx_d       = idx_q;
      gen_d       = gen_q;
      sent_d      = sent_q;
      stop_pend_d = stop_pend_q;
      gap_d       = gap_q;
      tx_data_d   = tx_data_q;

      unique case (state_q)
         S_IDLE: begin
            if (start_i && !stop_i) begin
               state_d     = S_WAIT_READY;
               burst_d     = burst_len_i;
               sent_d      = '0;
               idx_d       = '0;
               stop_pend_d = 1'b0;
               gen_d       = seed_i;
               if (pat_len_i == '0) begin
                  plen_d = PLEN_ONE;
               end else if (pat_len_i > PLEN_MAX) begin
                  plen_d = PLEN_MAX;
               end else begin
                  plen_d = pat_len_i;
               end
               case (mode_i)
                  2'd1:    gen_sel_d = GEN_INCR;
`ifdef UART_PATGEN_LFSR_EN
                  2'd2: begin
                     gen_sel_d = GEN_LFSR;
                     // The all-zero state would lock the LFSR up.
                     if (seed_i == '0) begin
                        gen_d = DATA_W'(1);
                     end
                  end
`else
                  2'd2:    gen_sel_d = GEN_INCR;
`endif
                  default: gen_sel_d = GEN_BUF;
               endcase
            end
         end

         S_WAIT_READY: begin
            if (stop_i) begin
               state_d = S_DONE;
            end else if (tx_if.tx_ready_i) begin
               state_d   = S_TRIGGER;
               tx_data_d = cur_byte;
            end
         end

         S_TRIGGER: begin
            if (stop_i) begin
               stop_pend_d = 1'b1;
            end
            state_d = S_WAIT_ACCEPT;
         end

         S_WAIT_ACCEPT: begin
            if (stop_i) begin
               stop_pend_d = 1'b1;
            end
            // Ready falling means the uart has taken the byte.
            if (!tx_if.tx_ready_i) begin
               sent_d = sat_inc(sent_q);
               case (gen_sel_q)
                  GEN_INCR: gen_d = gen_q + DATA_W'(1);
`ifdef UART_PATGEN_LFSR_EN
                  GEN_LFSR: gen_d = lfsr_next(gen_q);
`endif
                  default:  idx_d = wrap_inc(idx_q, plen_q);
               endcase
               if (((burst_q != '0) && (sent_d == burst_q)) || stop_pend_q || stop_i) begin
                  state_d = S_DONE;
               end else if (GAP_CYCLES == 0) begin
                  state_d = S_WAIT_READY;
               end else begin
                  state_d = S_GAP;
                  gap_d   = '0;
               end
            end
         end

         S_GAP: begin
            if (stop_i) begin
               state_d = S_DONE;
            end else if (gap_q == GAP_LAST) begin
               state_d = S_WAIT_READY;
            end else begin
               gap_d = gap_q + GW'(1);
            end
         end

         S_DONE: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule

// File: doc/uart_pattern_gen.md
# uart_pattern_gen

Parametrised UART transmit stimulus generator for board bring-up and link soak testing. It drives the `uart` block's transmit side (`tx_data_i` / `tx_trigger_i` / `tx_complete_o`) with bursts or continuous streams of bytes. The bytes come from a writable pattern buffer, an incrementing counter, or an optional LFSR. It sits between top-level control logic (buttons/LEDs or a command parser) and `uart`, and issues exactly one trigger per UART ready period.

## Interface
- `DATA_W`, 8: byte width; must be 8 when LFSR mode is compiled in.
- `DEPTH`, 16: pattern buffer entries (power of two); `AW = $clog2(DEPTH)`.
- `CNT_W`, 16: width of the burst-length and sent counters.
- `GAP_CYCLES`, 0: idle clocks inserted between a byte's acceptance and the next ready check.
- `clk_i` in 1: single clock.
- `rst_n_i` in 1: asynchronous, active-low reset.
- `start_i` in 1: start pulse; sampled only in IDLE.
- `stop_i` in 1: stop request; honoured at the next byte boundary.
- `mode_i` in 2: 0=BUFFER, 1=INCR, 2=LFSR, 3=reserved (behaves as BUFFER); sampled at start.
- `burst_len_i` in CNT_W: bytes per run, 0 = continuous; sampled at start.
- `pat_len_i` in AW+1: valid buffer entries, 1..DEPTH; 0 is treated as 1; sampled at start.
- `seed_i` in DATA_W: INCR start value / LFSR seed; sampled at start.
- `wr_en_i`, `wr_addr_i`[AW], `wr_data_i`[DATA_W], in: pattern buffer write port, usable at any time.
- `tx_data_o` out DATA_W: byte to UART.
- `tx_trigger_o` out 1: one-cycle send strobe to UART.
- `tx_ready_i` in 1: UART transmitter idle (`tx_complete_o`).
- `busy_o` out 1: run in progress.
- `done_o` out 1: one-cycle pulse at end of run.
- `sent_count_o` out CNT_W: bytes accepted this run; saturates at all-ones.

## Operation
- States: IDLE, WAIT_READY, TRIGGER, WAIT_ACCEPT, GAP, DONE.
- IDLE: on `start_i` (and not `stop_i`), latch the sampled inputs, clear `sent_count_o`, clear the buffer index, load the generator, then go to WAIT_READY. If `start_i` and `stop_i` are asserted together, stop wins and the block stays in IDLE. `start_i` is ignored outside IDLE.
- WAIT_READY: when `tx_ready_i`=1, go to TRIGGER.
- TRIGGER: `tx_trigger_o`=1 for this single cycle, with `tx_data_o` = current byte (held stable until the next TRIGGER). Then go to WAIT_ACCEPT.
- WAIT_ACCEPT: wait for `tx_ready_i`=0 (UART accepted the byte). When it falls:
  - increment `sent_count_o`;
  - advance the generator;
  - go to DONE if `burst_len_i`≠0 and the new count equals `burst_len_i`, or if a stop is pending;
  - otherwise go to GAP, or straight to WAIT_READY when `GAP_CYCLES`=0.
- GAP: count `GAP_CYCLES` clocks, then go to WAIT_READY.
- DONE: pulse `done_o` for one cycle, then go to IDLE.
- `stop_i` in WAIT_READY or GAP: go to DONE on the next cycle.
- `stop_i` in TRIGGER or WAIT_ACCEPT: latch a pending stop; the byte in flight completes first.
- Generators:
  - BUFFER: index wraps from `pat_len-1` to 0.
  - INCR: byte+1, modulo 2^DATA_W (0xFF→0x00).
  - LFSR (Galois): next = (x>>1) ^ (x[0] ? 0xB8 : 0x00). A seed of 0 is replaced by 0x01.
- Buffer writes take effect on the following cycle. A write to the entry currently being presented alters `tx_data_o` only at the next TRIGGER.

## Timing
- Reset values: `tx_data_o`=0, `tx_trigger_o`=0, `busy_o`=0, `done_o`=0, `sent_count_o`=0; state IDLE; buffer contents undefined.
- `start_i` at cycle n → `busy_o`=1 at n+1. The earliest `tx_trigger_o` is at n+2, given `tx_ready_i`=1.
- `busy_o` is high from the cycle after the start through the DONE cycle, and low in IDLE.
- `tx_ready_i` rise → trigger 1 cycle later. Trigger never repeats until a ready low→high cycle has completed.
- Reset asserted mid-run: all outputs return to reset values immediately; no `done_o` pulse.

## Configuration
- `UART_PATGEN_LFSR_EN` defined: mode 2 is the LFSR, and `DATA_W`≠8 is an elaboration error.
- `UART_PATGEN_LFSR_EN` undefined: no LFSR logic is built, and mode 2 behaves as INCR.

## Test plan
- BUFFER, `pat_len`=2 with buffer {0x41,0x43}, `burst_len`=5, ideal UART model → bytes 41 43 41 43 41; `sent_count_o`=5; one `done_o` pulse.
- INCR, `seed`=0xFE, `burst_len`=3 → bytes FE FF 00.
- LFSR (macro on), `seed`=0 → bytes 01 B8 5C. With the macro off, the same stimulus → 00 01 02.
- Continuous mode; `stop_i` asserted during WAIT_ACCEPT of byte 4 → byte 4 completes; `sent_count_o`=4; `done_o` pulses; no fifth trigger.
- `tx_ready_i` held high for 50 cycles after a trigger (slow acceptance) → exactly one trigger; `sent_count_o` unchanged until `tx_ready_i` falls.
- `GAP_CYCLES`=3 → ≥3 cycles from `tx_ready_i` fall to the next WAIT_READY. `rst_n_i` pulsed mid-gap → all outputs at reset values; a new `start_i` runs normally.
